ucsbece154b_mem_arbiter: RTL and testbench

Two-port read arbiter that shares the single SDRAM-controller read channel between the instruction cache's demand-miss port and the next-line prefetcher. It sits between both requesters and the SDRAM controller: it latches one block request at a time, drives the controller's request/address, and routes the returned burst beats to the owning requester. Demand misses always win a new arbitration. A demand miss to the block already being requested by a prefetch merges into that transaction rather than issuing a duplicate read.

---
 rtl/ucsbece154b_mem_pkg.sv | 26 ++
 rtl/ucsbece154b_beat_counter.sv | 33 +++
 rtl/ucsbece154b_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_ucsbece154b_mem_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_mem_pkg.sv
// Shared definitions for the instruction-side memory path: arbiter FSM states,
// transaction owner encoding and the block-address helper used by cache and arbiter.
package ucsbece154b_mem_pkg;

    localparam int BLOCK_WORDS     = 4;
    localparam int LOG_BLOCK_WORDS = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_e;

    typedef enum logic {
        DMD = 1'b0,
        PF  = 1'b1
    } owner_e;

    // Clears the word offset and the byte offset within a word.
    function automatic logic [63:0] block_addr(input logic [63:0] addr, input int log_words);
        logic [63:0] mask;
        mask = ~64'd0 << (log_words + 2);
        return addr & mask;
    endfunction

endpackage

// File: rtl/ucsbece154b_beat_counter.sv
// Saturating burst-beat counter; clear and enable may coincide (clear, then count).
// Combinational last flag marks the beat that brings the count to BLOCK_WORDS.
module ucsbece154b_beat_counter #(
    parameter int BLOCK_WORDS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last,
    output logic full
);

    localparam int CW = $clog2(BLOCK_WORDS + 1);

    logic [CW-1:0] count;
    logic [CW-1:0] base;

    always_comb begin
        base = clear ? '0 : count;
        last = enable && (base == CW'(BLOCK_WORDS - 1));
        full = (count == CW'(BLOCK_WORDS));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || enable) begin
            count <= (enable && (base != CW'(BLOCK_WORDS))) ? base + CW'(1) : base;
        end
    end

endmodule

// File: rtl/ucsbece154b_mem_arbiter.sv
// Shares the SDRAM read channel between demand misses and the next-line prefetcher.
// Latency: grant 1 cycle after request sampled in IDLE; beats 1 cycle after memDataReady.
// Backpressure: one block in flight; losing/mismatching requesters hold their request and wait.
module ucsbece154b_mem_arbiter #(
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 32,
    parameter int WORD_SIZE   = 32,
    parameter int IDX_W       = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dmdReq,
    input  logic [ADDR_W-1:0]    dmdAddr,
    output logic                 dmdGrant,
    output logic                 dmdValid,
    output logic                 dmdDone,
    input  logic                 pfReq,
    input  logic [ADDR_W-1:0]    pfAddr,
    output logic                 pfGrant,
    output logic                 pfValid,
    output logic                 pfDone,
    output logic [WORD_SIZE-1:0] beatData,
    output logic [IDX_W-1:0]     beatIndex,
    output logic                 memReadRequest,
    output logic [ADDR_W-1:0]    memReadAddress,
    input  logic [WORD_SIZE-1:0] memDataIn,
    input  logic                 memDataReady,
    input  logic [IDX_W-1:0]     memBlockIndex
);

    import ucsbece154b_mem_pkg::*;

    localparam int LOG_W = $clog2(BLOCK_WORDS);

    state_e            state;
    owner_e            owner;
    logic              merged;
    logic [ADDR_W-1:0] dmd_blk;
    logic [ADDR_W-1:0] pf_blk;
    logic              beat;
    logic              last;
    logic              full;
    logic              merge_now;
    logic              to_dmd;

    assign dmd_blk = ADDR_W'(block_addr(64'(dmdAddr), LOG_W));
    assign pf_blk  = ADDR_W'(block_addr(64'(pfAddr), LOG_W));

    // Once the counter saturates the block is complete; stray beats are ignored.
    assign beat      = memDataReady && ((state == REQ) || ((state == XFER) && !full));
    assign merge_now = (state == REQ) && (owner == PF) && !merged && dmdReq && (dmd_blk == memReadAddress);
    assign to_dmd    = (owner == DMD) || merged || merge_now;

    assign memReadRequest = (state == REQ);

    ucsbece154b_beat_counter #(
        .BLOCK_WORDS(BLOCK_WORDS)
    ) u_beat_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == REQ),
        .enable (beat),
        .last   (last),
        .full   (full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            owner          <= DMD;
            merged         <= 1'b0;
            memReadAddress <= '0;
            dmdGrant       <= 1'b0;
            pfGrant        <= 1'b0;
            dmdValid       <= 1'b0;
            pfValid        <= 1'b0;
            dmdDone        <= 1'b0;
            pfDone         <= 1'b0;
            beatData       <= '0;
            beatIndex      <= '0;
        end else begin
            dmdGrant <= 1'b0;
            pfGrant  <= 1'b0;
            dmdValid <= beat && to_dmd;
            pfValid  <= beat && (owner == PF);
            dmdDone  <= beat && last && to_dmd;
            pfDone   <= beat && last && (owner == PF);
            if (beat) begin
                beatData  <= memDataIn;
                beatIndex <= memBlockIndex;
            end
            case (state)
                IDLE: begin
                    if (dmdReq) begin
                        owner          <= DMD;
                        merged         <= 1'b0;
                        dmdGrant       <= 1'b1;
                        memReadAddress <= dmd_blk;
                        state          <= REQ;
                    end else if (pfReq) begin
                        owner          <= PF;
                        merged         <= 1'b0;
                        pfGrant        <= 1'b1;
                        memReadAddress <= pf_blk;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (merge_now) begin
                        merged   <= 1'b1;
                        dmdGrant <= 1'b1;
                    end
                    if (memDataReady) state <= XFER;
                end
                XFER: begin
                    // Leave only after the Done pulse so the requester can drop its request first.
                    if (dmdDone || pfDone) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Directed bench for the demand/prefetch read arbiter: walks demand-only, priority,
// merge, no-merge-in-XFER, stalled burst and mid-burst reset scenarios.
module tb_ucsbece154b_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        dmdReq;
    logic [31:0] dmdAddr;
    logic        dmdGrant, dmdValid, dmdDone;
    logic        pfReq;
    logic [31:0] pfAddr;
    logic        pfGrant, pfValid, pfDone;
    logic [31:0] beatData;
    logic [1:0]  beatIndex;
    logic        memReadRequest;
    logic [31:0] memReadAddress;
    logic [31:0] memDataIn;
    logic        memDataReady;
    logic [1:0]  memBlockIndex;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    ucsbece154b_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .dmdReq         (dmdReq),
        .dmdAddr        (dmdAddr),
        .dmdGrant       (dmdGrant),
        .dmdValid       (dmdValid),
        .dmdDone        (dmdDone),
        .pfReq          (pfReq),
        .pfAddr         (pfAddr),
        .pfGrant        (pfGrant),
        .pfValid        (pfValid),
        .pfDone         (pfDone),
        .beatData       (beatData),
        .beatIndex      (beatIndex),
        .memReadRequest (memReadRequest),
        .memReadAddress (memReadAddress),
        .memDataIn      (memDataIn),
        .memDataReady   (memDataReady),
        .memBlockIndex  (memBlockIndex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Delivers one 4-beat burst starting in REQ and checks every beat one cycle later.
    task automatic run_burst(input string tag, input logic [31:0] d0, input logic ev_d,
                             input logic ev_p, input int gap_at, input int raise_at,
                             input logic [31:0] raise_addr, input int exp_lat);
        int c0;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            memDataReady  = 1'b1;
            memDataIn     = d0 + 32'(i);
            memBlockIndex = 2'(i);
            step();
            chk({tag, "_dvalid"}, 64'(dmdValid), 64'(ev_d));
            chk({tag, "_pvalid"}, 64'(pfValid), 64'(ev_p));
            chk({tag, "_data"}, 64'(beatData), 64'(d0 + 32'(i)));
            chk({tag, "_index"}, 64'(beatIndex), 64'(i));
            chk({tag, "_ddone"}, 64'(dmdDone), 64'((i == 3) && ev_d));
            chk({tag, "_pdone"}, 64'(pfDone), 64'((i == 3) && ev_p));
            chk({tag, "_req_low"}, 64'(memReadRequest), 64'(0));
            if (i == gap_at) begin
                memDataReady = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    step();
                    chk({tag, "_gap_valid"}, 64'({dmdValid, pfValid, dmdDone, pfDone}), 64'(0));
                end
            end
            if (i == raise_at) begin
                dmdReq  = 1'b1;
                dmdAddr = raise_addr;
            end
        end
        memDataReady = 1'b0;
        chk({tag, "_done_latency"}, 64'(cyc - c0), 64'(exp_lat));
    endtask

    initial begin
        reset = 1'b0; dmdReq = 1'b0; dmdAddr = '0; pfReq = 1'b0; pfAddr = '0;
        memDataIn = '0; memDataReady = 1'b0; memBlockIndex = '0;

        // Reset state
        #2;
        chk("reset_flags", 64'({dmdGrant, dmdValid, dmdDone, pfGrant, pfValid, pfDone, memReadRequest}), 64'(0));
        chk("reset_addr", 64'(memReadAddress), 64'(0));
        chk("reset_beat", 64'({beatData, beatIndex}), 64'(0));
        #10 reset = 1'b1;
        step();
        chk("idle_req", 64'(memReadRequest), 64'(0));

        // Demand only, controller replies after 3 request cycles
        dmdReq = 1'b1; dmdAddr = 32'h1004;
        step();
        chk("t1_grant", 64'({dmdGrant, pfGrant}), 64'b10);
        chk("t1_req", 64'(memReadRequest), 64'(1));
        chk("t1_addr", 64'(memReadAddress), 64'h1000);
        step();
        chk("t1_grant_pulse", 64'(dmdGrant), 64'(0));
        chk("t1_req_held", 64'(memReadRequest), 64'(1));
        step();
        run_burst("t1", 32'hA0, 1'b1, 1'b0, -1, -1, 32'h0, 4);
        dmdReq = 1'b0;
        step();
        chk("t1_idle", 64'({memReadRequest, dmdGrant, pfGrant}), 64'(0));

        // Simultaneous requests: demand first, prefetch after the IDLE cycle
        dmdReq = 1'b1; dmdAddr = 32'h2000;
        pfReq  = 1'b1; pfAddr  = 32'h3000;
        step();
        chk("t2_grant", 64'({dmdGrant, pfGrant}), 64'b10);
        chk("t2_addr", 64'(memReadAddress), 64'h2000);
        step();
        run_burst("t2d", 32'hB0, 1'b1, 1'b0, -1, -1, 32'h0, 4);
        dmdReq = 1'b0;
        step();
        chk("t2_idle_gap", 64'({pfGrant, memReadRequest}), 64'(0));
        step();
        chk("t2_pf_grant", 64'({dmdGrant, pfGrant}), 64'b01);
        chk("t2_pf_addr", 64'(memReadAddress), 64'h3000);
        chk("t2_pf_req", 64'(memReadRequest), 64'(1));
        step();

        // Demand to the prefetch block raised during XFER: no merge
        run_burst("t4p", 32'hC0, 1'b0, 1'b1, -1, 0, 32'h3008, 4);
        pfReq = 1'b0;
        step();
        chk("t4_wait", 64'({dmdGrant, memReadRequest}), 64'(0));
        step();
        chk("t4_dmd_grant", 64'(dmdGrant), 64'(1));
        chk("t4_second_read", 64'(memReadRequest), 64'(1));
        chk("t4_addr", 64'(memReadAddress), 64'h3000);
        step();

        // Stalled burst: two idle cycles between beats 2 and 3
        run_burst("t5", 32'hD0, 1'b1, 1'b0, 2, -1, 32'h0, 6);
        dmdReq = 1'b0;
        step();

        // Merge: demand to the latched prefetch block while in REQ
        pfReq = 1'b1; pfAddr = 32'h4010;
        step();
        chk("t3_pf_grant", 64'({dmdGrant, pfGrant}), 64'b01);
        chk("t3_addr", 64'(memReadAddress), 64'h4010);
        dmdReq = 1'b1; dmdAddr = 32'h401C;
        step();
        chk("t3_merge_grant", 64'({dmdGrant, pfGrant}), 64'b10);
        chk("t3_req", 64'(memReadRequest), 64'(1));
        step();
        chk("t3_merge_pulse", 64'(dmdGrant), 64'(0));
        run_burst("t3", 32'hE0, 1'b1, 1'b1, -1, -1, 32'h0, 4);
        dmdReq = 1'b0; pfReq = 1'b0;
        step();
        chk("t3_no_dup_a", 64'({memReadRequest, dmdGrant, pfGrant}), 64'(0));
        step();
        chk("t3_no_dup_b", 64'({memReadRequest, dmdGrant, pfGrant}), 64'(0));

        // Asynchronous reset in the middle of a burst
        pfReq = 1'b1; pfAddr = 32'h5000;
        step();
        chk("t6_grant", 64'(pfGrant), 64'(1));
        memDataReady = 1'b1; memDataIn = 32'hF0; memBlockIndex = 2'd0;
        step();
        memDataIn = 32'hF1; memBlockIndex = 2'd1;
        step();
        chk("t6_beat", 64'({pfValid, beatData}), 64'({1'b1, 32'hF1}));
        #2 reset = 1'b0;
        #1;
        chk("t6_async_flags", 64'({dmdGrant, dmdValid, dmdDone, pfGrant, pfValid, pfDone, memReadRequest}), 64'(0));
        chk("t6_async_data", 64'({beatData, beatIndex}), 64'(0));
        chk("t6_async_addr", 64'(memReadAddress), 64'(0));
        memDataReady = 1'b0; pfReq = 1'b0;
        step();
        reset = 1'b1;
        step();
        dmdReq = 1'b1; dmdAddr = 32'h6000;
        step();
        chk("t6_post_grant", 64'({dmdGrant, memReadRequest}), 64'b11);
        chk("t6_post_addr", 64'(memReadAddress), 64'h6000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
